reg_port_arbiter: RTL
=====================

// Module: reg_port_arbiter
// PURPOSE
//  Two-client arbiter for the 8x8 register file's single address/write port (write addr = read addr A).
//  Client 0 is the core datapath; client 1 is the loader/debug path.
//  One read or write transaction is granted per cycle, with core priority and starvation relief for the loader.
//  Owns the register file's Ra/Wen/Wdat; read data returns as a registered one-cycle response.
// PARAMETERS
//  DW           8  data width
//  AW           3  register address width
//  STARVE_LIMIT 4  cycles client 1 may wait while valid before it takes priority (>=1)
// PORTS
//  Clk        in   1   clock, all state on posedge
//  Reset_n    in   1   asynchronous, active-low reset
//  Req0Valid  in   1   client 0 transaction request
//  Req0Wr     in   1   1 = write, 0 = read
//  Req0Addr   in   AW  register index
//  Req0Data   in   DW  write data (ignored on read)
//  Req0Ready  out  1   client 0 transaction accepted this cycle
//  Rsp0Valid  out  1   client 0 response, 1-cycle pulse
//  Rsp0Data   out  DW  read data, or echoed write data
//  Req1Valid / Req1Wr / Req1Addr / Req1Data / Req1Ready / Rsp1Valid / Rsp1Data: same as client 0, for client 1
//  RfRa       out  AW  register file address A (also the write address)
//  RfWen      out  1   register file write enable
//  RfWdat     out  DW  register file write data
//  RfRdatA    in   DW  register file read data A (combinational from RfRa)
//  Starved    out  1   high while FSM is in STARVED
// BEHAVIOUR
//  - Accept = ReqNValid & ReqNReady.
//    - Ready is combinational from the Valids and FSM state.
//    - At most one Ready per cycle; a Ready is never raised without its Valid.
//  - Grant:
//    - NORMAL: client 0 wins if valid, else client 1.
//    - STARVED: client 1 wins if valid, else client 0.
//  - Granted cycle, combinational:
//    - RfRa = ReqAddr; RfWen = ReqWr; RfWdat = ReqData.
//    - No grant: RfRa = 0, RfWen = 0, RfWdat = 0.
//  - Write commits at the accepting posedge.
//  - Response, registered at the accepting posedge:
//    - RspNValid = 1 for exactly the next cycle.
//    - RspNData = RfRdatA (read) or ReqData (write).
//    - Read latency 1 cycle; back-to-back accepts give back-to-back responses.
//  - RAW: write at edge t, then read of same address accepted in cycle t+1, returns the new data.
//  - Requests are not buffered. A non-accepted request must be held until Ready; the arbiter never drops an accepted one.
//  - Responses have no backpressure; the client must consume them in the valid cycle.
//  - WaitCnt, width clog2(STARVE_LIMIT+1):
//    - +1 each cycle Req1Valid & !Req1Ready, saturating at STARVE_LIMIT.
//    - Cleared on a client 1 accept or when Req1Valid = 0.
//  - FSM states:
//    - NORMAL -> STARVED when WaitCnt == STARVE_LIMIT at the posedge.
//    - STARVED -> NORMAL on a client 1 accept, or if Req1Valid drops.
//    - Boost granularity: exactly one client 1 transaction per starvation event.
//  - Simultaneous valids in NORMAL: client 0 served and WaitCnt increments. Worst-case client 1 wait is STARVE_LIMIT+1 cycles.
//  - Reset, asynchronous, may occur mid-transaction:
//    - FSM = NORMAL, WaitCnt = 0.
//    - Rsp0Valid = Rsp1Valid = 0, Rsp0Data = Rsp1Data = 0.
//    - Any accepted-but-unresponded read is discarded.
//    - Ready, RfWen, RfRa, RfWdat are 0 while Reset_n is low.
//    - Reset does not clear register file contents.
// TESTING
//  1. After reset: c0 write r3 = 0xA5, then c0 read r3 next cycle -> Rsp0Valid one cycle after each accept, read Rsp0Data = 0xA5.
//  2. Both valid in the same cycle, NORMAL: c0 read r1, c1 write r2 = 0x3C -> Req0Ready = 1, Req1Ready = 0, RfWen = 0, RfRa = 1.
//  3. c0 valid every cycle, c1 holds write r7 = 0x77:
//     - Starved = 1 after 4 waits; c1 accepted on the 5th cycle, c0 stalled that cycle.
//     - Starved = 0 next cycle; r7 reads 0x77.
//  4. Alternating-client reads of r0..r7 after writing 0x10 + i: responses back-to-back, each tagged to the correct client with data 0x10 + i.
//  5. Reset_n low in the cycle after a c1 read accept -> Rsp1Valid stays 0 and Starved = 0; the r-file still holds the prior writes.
//  6. c1 drops Req1Valid at WaitCnt = 3, then re-requests -> WaitCnt restarts at 0; no STARVED entry before 4 further waits.

Source files
------------

// File: rtl/reg_port_arbiter.sv
// Two-client arbiter for the register file's shared address/write port.
// Client 0 (core) has priority; client 1 (loader) gets one boosted grant after waiting STARVE_LIMIT cycles.
module reg_port_arbiter #(
    parameter int DW           = 8,
    parameter int AW           = 3,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Req0Valid,
    input  logic          Req0Wr,
    input  logic [AW-1:0] Req0Addr,
    input  logic [DW-1:0] Req0Data,
    output logic          Req0Ready,
    output logic          Rsp0Valid,
    output logic [DW-1:0] Rsp0Data,
    input  logic          Req1Valid,
    input  logic          Req1Wr,
    input  logic [AW-1:0] Req1Addr,
    input  logic [DW-1:0] Req1Data,
    output logic          Req1Ready,
    output logic          Rsp1Valid,
    output logic [DW-1:0] Rsp1Data,
    output logic [AW-1:0] RfRa,
    output logic          RfWen,
    output logic [DW-1:0] RfWdat,
    input  logic [DW-1:0] RfRdatA,
    output logic          Starved
);

    localparam int            CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic {
        ST_NORMAL  = 1'b0,
        ST_STARVED = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_wait_cnt;
    logic [CW-1:0] w_wait_cnt_nxt;
    logic          w_grant0;
    logic          w_grant1;
    logic          r_rsp0_valid;
    logic          r_rsp1_valid;
    logic [DW-1:0] r_rsp0_data;
    logic [DW-1:0] r_rsp1_data;

    // Handshake: a request transfers in any cycle where ReqNValid & ReqNReady.
    // Ready depends combinationally on both Valids and the FSM state, is never
    // raised without its Valid, and at most one Ready is high per cycle.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (Reset_n) begin
            case (r_state)
                ST_STARVED: begin
                    w_grant1 = Req1Valid;
                    w_grant0 = Req0Valid & ~Req1Valid;
                end
                default: begin
                    w_grant0 = Req0Valid;
                    w_grant1 = Req1Valid & ~Req0Valid;
                end
            endcase
        end
    end

    always_comb begin
        w_wait_cnt_nxt = r_wait_cnt;
        if (!Req1Valid || w_grant1) begin
            w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt != LIMIT) begin
            w_wait_cnt_nxt = r_wait_cnt + CW'(1);
        end
    end

    // The boost takes effect on the edge where the counter reaches the limit,
    // so client 1 is served on its (STARVE_LIMIT+1)-th waiting cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_NORMAL: begin
                if (w_wait_cnt_nxt == LIMIT) begin
                    w_state_nxt = ST_STARVED;
                end
            end
            ST_STARVED: begin
                if (!Req1Valid || w_grant1) begin
                    w_state_nxt = ST_NORMAL;
                end
            end
            default: w_state_nxt = ST_NORMAL;
        endcase
    end

    always_comb begin
        RfRa   = '0;
        RfWen  = 1'b0;
        RfWdat = '0;
        if (w_grant0) begin
            RfRa   = Req0Addr;
            RfWen  = Req0Wr;
            RfWdat = Req0Data;
        end else if (w_grant1) begin
            RfRa   = Req1Addr;
            RfWen  = Req1Wr;
            RfWdat = Req1Data;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= ST_NORMAL;
            r_wait_cnt   <= '0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_data  <= '0;
            r_rsp1_data  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_wait_cnt   <= w_wait_cnt_nxt;
            r_rsp0_valid <= w_grant0;
            r_rsp1_valid <= w_grant1;
            if (w_grant0) begin
                r_rsp0_data <= Req0Wr ? Req0Data : RfRdatA;
            end
            if (w_grant1) begin
                r_rsp1_data <= Req1Wr ? Req1Data : RfRdatA;
            end
        end
    end

    assign Req0Ready = w_grant0;
    assign Req1Ready = w_grant1;
    assign Rsp0Valid = r_rsp0_valid;
    assign Rsp1Valid = r_rsp1_valid;
    assign Rsp0Data  = r_rsp0_data;
    assign Rsp1Data  = r_rsp1_data;
    assign Starved   = (r_state == ST_STARVED);

endmodule
